// File: rtl/time_display_driver.sv
// Multiplexed HH:MM 7-segment driver: captures one time value per scan frame and scans four digits.
// Optional HR_LZ_BLANK_EN: blanks a zero hour-tens digit on a valid time.
module time_display_driver #(
  parameter int SCAN_DIV = 1000
) (
  input  logic        CLK,
  input  logic        RESETN,
  input  logic [10:0] DISPLAY_BUS,
  input  logic        ENABLE,
  output logic [6:0]  SEG_OUT,
  output logic [3:0]  DIG_SEL,
  output logic        COLON,
  output logic        AMPM_LED
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PCNT_MAX = PW'(SCAN_DIV - 1);

  logic [PW-1:0] pcnt_q, pcnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [10:0]   cap_q, cap_d;
  logic          ht_q, ht_d;
  logic [3:0]    hu_q, hu_d;
  logic [2:0]    mt_q, mt_d;
  logic [3:0]    mu_q, mu_d;
  logic          valid_q, valid_d;
  logic          pm_q, pm_d;
  logic [6:0]    seg_q, seg_d;
  logic [3:0]    dig_q, dig_d;
  logic          colon_q, colon_d;
  logic          ampm_q, ampm_d;

  logic [3:0] hrs;
  logic [5:0] mins;
  logic [3:0] digit;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h3F;
      4'd1:    seg7 = 7'h06;
      4'd2:    seg7 = 7'h5B;
      4'd3:    seg7 = 7'h4F;
      4'd4:    seg7 = 7'h66;
      4'd5:    seg7 = 7'h6D;
      4'd6:    seg7 = 7'h7D;
      4'd7:    seg7 = 7'h07;
      4'd8:    seg7 = 7'h7F;
      4'd9:    seg7 = 7'h6F;
      default: seg7 = 7'h40;
    endcase
  endfunction

  always_comb begin
    pcnt_d = pcnt_q;
    idx_d  = idx_q;
    cap_d  = cap_q;
    if (!ENABLE) begin
      pcnt_d = '0;
      idx_d  = '0;
    end else begin
      if (pcnt_q == PCNT_MAX) begin
        pcnt_d = '0;
        idx_d  = idx_q + 2'd1;
      end else begin
        pcnt_d = pcnt_q + 1'b1;
      end
      if (pcnt_q == '0 && idx_q == 2'd0) cap_d = DISPLAY_BUS;
    end

    // BCD is converted from the incoming CAP value so it lands together with the
    // capture; digit 0's first lit cycle then already shows the new frame.
    hrs     = cap_d[9:6];
    mins    = cap_d[5:0];
    ht_d    = (hrs >= 4'd10);
    hu_d    = ht_d ? (hrs - 4'd10) : hrs;
    mt_d    = 3'(mins / 6'd10);
    mu_d    = 4'(mins % 6'd10);
    valid_d = (hrs != 4'd0) && (hrs <= 4'd12) && (mins <= 6'd59);
    pm_d    = cap_d[10];
  end

  always_comb begin
    case (idx_q)
      2'd0:    digit = {3'b000, ht_q};
      2'd1:    digit = hu_q;
      2'd2:    digit = {1'b0, mt_q};
      default: digit = mu_q;
    endcase

    seg_d   = '0;
    dig_d   = '0;
    colon_d = ENABLE && valid_q;
    ampm_d  = ENABLE && valid_q && pm_q;
    // PCNT=0 is the ghost-blanking slot between digits.
    if (ENABLE && pcnt_q != '0) begin
      dig_d = 4'b0001 << idx_q;
      seg_d = valid_q ? seg7(digit) : 7'h40;
`ifdef HR_LZ_BLANK_EN
      if (valid_q && idx_q == 2'd0 && !ht_q) seg_d = '0;
`endif
    end
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      pcnt_q  <= '0;
      idx_q   <= '0;
      cap_q   <= '0;
      ht_q    <= 1'b0;
      hu_q    <= '0;
      mt_q    <= '0;
      mu_q    <= '0;
      valid_q <= 1'b0;
      pm_q    <= 1'b0;
      seg_q   <= '0;
      dig_q   <= '0;
      colon_q <= 1'b0;
      ampm_q  <= 1'b0;
    end else begin
      pcnt_q  <= pcnt_d;
      idx_q   <= idx_d;
      cap_q   <= cap_d;
      ht_q    <= ht_d;
      hu_q    <= hu_d;
      mt_q    <= mt_d;
      mu_q    <= mu_d;
      valid_q <= valid_d;
      pm_q    <= pm_d;
      seg_q   <= seg_d;
      dig_q   <= dig_d;
      colon_q <= colon_d;
      ampm_q  <= ampm_d;
    end
  end

  assign SEG_OUT  = seg_q;
  assign DIG_SEL  = dig_q;
  assign COLON    = colon_q;
  assign AMPM_LED = ampm_q;

endmodule
